// File: rtl/mem_ctrl_arb_pkg.sv
// Shared types and helpers for the mem_ctrl_arb memory controller.
// Optional misalignment checking is enabled by defining MEM_CTRL_MISALIGN_CHK_EN.
package mem_ctrl_pkg;

    // Access size encodings carried on ls_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Per-port access state; both ports share this encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte enables for an access of 2**size bytes at byte offset off.
    // Computed for the widest (8-lane) word; callers keep the low lanes,
    // which drops any bytes that would spill past the word boundary.
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = (16'd1 << (4'd1 << size)) - 16'd1;
        m = m << off;
        return m[7:0];
    endfunction

    // True when the byte offset is not a multiple of the access size
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic [3:0] mask;
        mask = (4'd1 << size) - 4'd1;
        return (({1'b0, off} & mask) != 4'd0);
    endfunction

    // Sign/zero extension of a right-aligned load value to 64 bits
    function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [1:0] size,
                                             input logic uns);
        logic [63:0] r;
        case (size)
            SZ_B:    r = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    r = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    r = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb_if.sv
// Bundle of fetch, load/store and RAM-side signals for mem_ctrl_arb.
// Handshake: a requester raises valid and holds it (with its address and
// data stable) until the matching one-cycle done pulse; done is never
// asserted without a pending request. a_state/b_state expose the FSMs.
// ls_err exists only when MEM_CTRL_MISALIGN_CHK_EN is defined.
interface mem_ctrl_arb_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LS     = 2
);
    logic                           if_valid;
    logic [ADDR_WIDTH-1:0]          if_addr;
    logic                           if_done;
    logic [DATA_WIDTH-1:0]          if_data;

    logic [NUM_LS-1:0]              ls_valid;
    logic [NUM_LS-1:0]              ls_we;
    logic [2*NUM_LS-1:0]            ls_size;
    logic [NUM_LS-1:0]              ls_unsigned;
    logic [NUM_LS*ADDR_WIDTH-1:0]   ls_addr;
    logic [NUM_LS*DATA_WIDTH-1:0]   ls_src;
    logic [NUM_LS-1:0]              ls_done;
    logic [DATA_WIDTH-1:0]          ls_data;

    logic [ADDR_WIDTH-1:0]          addr_a;
    logic [DATA_WIDTH-1:0]          data_a;
    logic [ADDR_WIDTH-1:0]          addr_b;
    logic [DATA_WIDTH/8-1:0]        be_b;
    logic [DATA_WIDTH-1:0]          src_b;
    logic [DATA_WIDTH-1:0]          data_b;

    state_t                         a_state;
    state_t                         b_state;

`ifdef MEM_CTRL_MISALIGN_CHK_EN
    logic                           ls_err;

    modport slave (
        input  if_valid, if_addr, ls_valid, ls_we, ls_size, ls_unsigned, ls_addr, ls_src,
        input  data_a, data_b,
        output if_done, if_data, ls_done, ls_data, ls_err,
        output addr_a, addr_b, be_b, src_b, a_state, b_state
    );
    modport master (
        output if_valid, if_addr, ls_valid, ls_we, ls_size, ls_unsigned, ls_addr, ls_src,
        output data_a, data_b,
        input  if_done, if_data, ls_done, ls_data, ls_err,
        input  addr_a, addr_b, be_b, src_b, a_state, b_state
    );
`else
    modport slave (
        input  if_valid, if_addr, ls_valid, ls_we, ls_size, ls_unsigned, ls_addr, ls_src,
        input  data_a, data_b,
        output if_done, if_data, ls_done, ls_data,
        output addr_a, addr_b, be_b, src_b, a_state, b_state
    );
    modport master (
        output if_valid, if_addr, ls_valid, ls_we, ls_size, ls_unsigned, ls_addr, ls_src,
        output data_a, data_b,
        input  if_done, if_data, ls_done, ls_data,
        input  addr_a, addr_b, be_b, src_b, a_state, b_state
    );
`endif

endinterface

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0]                    req,
    input  logic                            accept,
    output logic [N-1:0]                    grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
    output logic                            any
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic          found;

    assign any = |req;

    // Scan priorities from the pointer outward and pick the first requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((i - int'(ptr) + N) % N) == k)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IW'(i);
                end
            end
        end
    end

    // Advance the pointer to the channel after the accepted winner
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && any) begin
            if (int'(grant_idx) == N - 1) ptr <= '0;
            else                          ptr <= grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Dual-port block-RAM controller: port A serves instruction fetch, port B
// serves NUM_LS load/store channels under round-robin arbitration with
// byte/half/word/dword sizes and load extension. Each port runs its own
// IDLE/WAIT/DONE FSM with a RAM_LAT-cycle wait.
// Define MEM_CTRL_MISALIGN_CHK_EN to reject misaligned accesses with ls_err
// instead of truncating their byte enables.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LS     = 2,
    parameter int RAM_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_ctrl_arb_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam int IW = (NUM_LS > 1) ? $clog2(NUM_LS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);

    // ---------------- Port A: instruction fetch ----------------
    state_t                state_a;
    logic [CW-1:0]         cnt_a;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic                  if_done_q;
    logic [DATA_WIDTH-1:0] if_data_q;

    assign bus.addr_a  = addr_a_q;
    assign bus.if_done = if_done_q;
    assign bus.if_data = if_data_q;
    assign bus.a_state = state_a;

    // Fetch FSM: issue, wait out the RAM latency, capture, one idle DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_a   <= IDLE;
            cnt_a     <= '0;
            addr_a_q  <= '0;
            if_done_q <= 1'b0;
            if_data_q <= '0;
        end else begin
            case (state_a)
                IDLE: begin
                    if (bus.if_valid) begin
                        addr_a_q <= bus.if_addr;
                        cnt_a    <= CW'(RAM_LAT - 1);
                        state_a  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_a == '0) begin
                        if_data_q <= bus.data_a;
                        if_done_q <= 1'b1;
                        addr_a_q  <= '0;
                        state_a   <= DONE;
                    end else begin
                        cnt_a <= cnt_a - CW'(1);
                    end
                end
                DONE: begin
                    if_done_q <= 1'b0;
                    state_a   <= IDLE;
                end
                default: state_a <= IDLE;
            endcase
        end
    end

    // ---------------- Port B: load/store channels ----------------
    state_t                state_b;
    logic [CW-1:0]         cnt_b;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic [NB-1:0]         be_b_q;
    logic [DATA_WIDTH-1:0] src_b_q;
    logic [NUM_LS-1:0]     ls_done_q;
    logic [DATA_WIDTH-1:0] ls_data_q;

    logic [NUM_LS-1:0]     g_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [2:0]            off_q;

    logic [NUM_LS-1:0]     grant;
    logic [IW-1:0]         grant_idx;
    logic                  arb_any;
    logic                  arb_accept;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [1:0]            sel_size;
    logic                  sel_uns;
    logic [DATA_WIDTH-1:0] sel_src;
    logic [2:0]            sel_off;
    logic [7:0]            be_full;
    logic                  mis_hit;
    logic [63:0]           ext;

    assign bus.addr_b  = addr_b_q;
    assign bus.be_b    = be_b_q;
    assign bus.src_b   = src_b_q;
    assign bus.ls_done = ls_done_q;
    assign bus.ls_data = ls_data_q;
    assign bus.b_state = state_b;

    assign arb_accept = (state_b == IDLE);

    rr_arbiter #(.N(NUM_LS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.ls_valid),
        .accept    (arb_accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (arb_any)
    );

    // Route the granted channel's request fields
    always_comb begin
        sel_addr = '0;
        sel_we   = 1'b0;
        sel_size = SZ_B;
        sel_uns  = 1'b0;
        sel_src  = '0;
        for (int i = 0; i < NUM_LS; i++) begin
            if (int'(grant_idx) == i) begin
                sel_addr = bus.ls_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we   = bus.ls_we[i];
                sel_size = bus.ls_size[2*i +: 2];
                sel_uns  = bus.ls_unsigned[i];
                sel_src  = bus.ls_src[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_off = 3'(sel_addr & OFF_MASK);
    assign be_full = be_gen(sel_size, sel_off);
    assign ext     = load_ext(64'(bus.data_b >> {off_q, 3'b000}), size_q, uns_q);

`ifdef MEM_CTRL_MISALIGN_CHK_EN
    logic ls_err_q;
    assign mis_hit    = misaligned(sel_size, sel_off);
    assign bus.ls_err = ls_err_q;

    // Error flag pulses alongside ls_done for a rejected misaligned grant
    always_ff @(posedge clk) begin
        if (rst) ls_err_q <= 1'b0;
        else     ls_err_q <= (state_b == IDLE) && arb_any && mis_hit;
    end
`else
    assign mis_hit = 1'b0;
`endif

    // Load/store FSM: arbitrate and issue, wait out the latency, complete
    always_ff @(posedge clk) begin
        if (rst) begin
            state_b   <= IDLE;
            cnt_b     <= '0;
            addr_b_q  <= '0;
            be_b_q    <= '0;
            src_b_q   <= '0;
            ls_done_q <= '0;
            ls_data_q <= '0;
            g_q       <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            off_q     <= '0;
        end else begin
            case (state_b)
                IDLE: begin
                    if (arb_any) begin
                        g_q    <= grant;
                        we_q   <= sel_we;
                        size_q <= sel_size;
                        uns_q  <= sel_uns;
                        off_q  <= sel_off;
                        if (mis_hit) begin
                            // Rejected: no RAM access, finish immediately
                            ls_done_q <= grant;
                            state_b   <= DONE;
                        end else begin
                            addr_b_q <= sel_addr & ~OFF_MASK;
                            be_b_q   <= sel_we ? be_full[NB-1:0] : '0;
                            src_b_q  <= sel_we ? (sel_src << {sel_off, 3'b000}) : '0;
                            cnt_b    <= CW'(RAM_LAT - 1);
                            state_b  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_b == '0) begin
                        if (!we_q) ls_data_q <= ext[DATA_WIDTH-1:0];
                        ls_done_q <= g_q;
                        addr_b_q  <= '0;
                        be_b_q    <= '0;
                        src_b_q   <= '0;
                        state_b   <= DONE;
                    end else begin
                        cnt_b <= cnt_b - CW'(1);
                    end
                end
                DONE: begin
                    ls_done_q <= '0;
                    state_b   <= IDLE;
                end
                default: state_b <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed bench for mem_ctrl_arb: one instance with RAM_LAT=1 (fetch,
// load/store, arbitration, reset) and one with RAM_LAT=3 (fetch latency).
module tb_mem_ctrl_arb;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_ctrl_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LS(2)) b1 ();
    mem_ctrl_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LS(2)) b3 ();

    mem_ctrl_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LS(2), .RAM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_ctrl_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LS(2), .RAM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    // RAM models: dut1 reads combinationally, dut3 sees the address two cycles late
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] a3_d1 = '0;
    logic [31:0] a3_d2 = '0;

    assign b1.data_a = mem1[b1.addr_a[9:2]];
    assign b1.data_b = mem1[b1.addr_b[9:2]];
    assign b3.data_a = mem3[a3_d2[9:2]];
    assign b3.data_b = '0;

    always @(posedge clk) begin
        a3_d1 <= b3.addr_a;
        a3_d2 <= a3_d1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (b1.be_b[i]) mem1[b1.addr_b[9:2]][8*i +: 8] = b1.src_b[8*i +: 8];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ls_drive(input int ch, input logic v, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] src);
        b1.ls_valid[ch]          = v;
        b1.ls_we[ch]             = we;
        b1.ls_size[2*ch +: 2]    = size;
        b1.ls_unsigned[ch]       = uns;
        b1.ls_addr[32*ch +: 32]  = addr;
        b1.ls_src[32*ch +: 32]   = src;
    endtask

    // One complete single-channel access; returns ls_data/ls_done at the done edge
    task automatic ls_single(input int ch, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] src,
                             output logic [31:0] data, output logic [1:0] done);
        ls_drive(ch, 1'b1, we, size, uns, addr, src);
        tick();
        tick();
        data = b1.ls_data;
        done = b1.ls_done;
        b1.ls_valid[ch] = 1'b0;
        tick();
    endtask

    logic [31:0] d;
    logic [1:0]  dn;
    int          first_done;
    int          n_done;
    int          exp_ch;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem1[8'h40] = 32'hDEADBEEF;   // 0x100
        mem1[8'h81] = 32'h92345678;   // 0x204
        mem3[8'h10] = 32'hCAFEF00D;   // 0x040

        b1.if_valid = 1'b0; b1.if_addr = '0; b1.ls_valid = '0; b1.ls_we = '0;
        b1.ls_size = '0; b1.ls_unsigned = '0; b1.ls_addr = '0; b1.ls_src = '0;
        b3.if_valid = 1'b0; b3.if_addr = '0; b3.ls_valid = '0; b3.ls_we = '0;
        b3.ls_size = '0; b3.ls_unsigned = '0; b3.ls_addr = '0; b3.ls_src = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_if_done", b1.if_done, 0);
        chk("rst_ls_done", b1.ls_done, 0);
        chk("rst_addr_a",  b1.addr_a, 0);
        chk("rst_addr_b",  b1.addr_b, 0);
        chk("rst_be_b",    b1.be_b, 0);
        chk("rst_ls_data", b1.ls_data, 0);
        chk("rst_a_state", b1.a_state, IDLE);
        chk("rst_b_state", b1.b_state, IDLE);

        // RAM_LAT=3 fetch: done exactly on the 4th edge, one pulse
        b3.if_valid = 1'b1;
        b3.if_addr  = 32'h40;
        first_done  = 0;
        n_done      = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) chk("lat3_addr_a", b3.addr_a, 32'h40);
            if (b3.if_done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    chk("lat3_if_data", b3.if_data, 32'hCAFEF00D);
                end
                b3.if_valid = 1'b0;
            end
        end
        chk("lat3_done_edge", first_done, 4);
        chk("lat3_done_cnt",  n_done, 1);

        // RAM_LAT=1 fetch, valid held through DONE
        b1.if_valid = 1'b1;
        b1.if_addr  = 32'h100;
        tick();
        chk("f_addr_a", b1.addr_a, 32'h100);
        chk("f_done_early", b1.if_done, 0);
        tick();
        chk("f_done", b1.if_done, 1);
        chk("f_data", b1.if_data, 32'hDEADBEEF);
        chk("f_addr_clr", b1.addr_a, 0);
        tick();
        chk("f_done_pulse", b1.if_done, 0);
        chk("f_no_reissue", b1.addr_a, 0);
        b1.if_valid = 1'b0;
        tick();
        chk("f_idle_addr", b1.addr_a, 0);
        chk("f_data_held", b1.if_data, 32'hDEADBEEF);

        // Byte store ch0 at 0x203
        ls_drive(0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h203, 32'h5A);
        tick();
        chk("st_addr_b", b1.addr_b, 32'h200);
        chk("st_be_b",   b1.be_b, 4'b1000);
        chk("st_src_b",  b1.src_b, 32'h5A000000);
        tick();
        chk("st_done",   b1.ls_done, 2'b01);
        chk("st_be_clr", b1.be_b, 0);
        chk("st_data_unchanged", b1.ls_data, 0);
        b1.ls_valid[0] = 1'b0;
        tick();
        chk("st_done_pulse", b1.ls_done, 0);

        ls_single(0, 1'b0, SZ_B, 1'b0, 32'h203, 32'h0, d, dn);
        chk("ldb_s_5a", d, 32'h0000005A);
        chk("ldb_s_5a_done", dn, 2'b01);
        ls_single(0, 1'b1, SZ_B, 1'b0, 32'h203, 32'h80, d, dn);
        chk("st80_data_held", d, 32'h0000005A);
        ls_single(0, 1'b0, SZ_B, 1'b0, 32'h203, 32'h0, d, dn);
        chk("ldb_s_80", d, 32'hFFFFFF80);
        ls_single(1, 1'b0, SZ_B, 1'b1, 32'h203, 32'h0, d, dn);
        chk("ldb_u_80", d, 32'h00000080);
        chk("ldb_u_done_ch1", dn, 2'b10);

        // Both channels continuously valid: grants 0,1,0,1
        ls_drive(0, 1'b1, 1'b0, SZ_W, 1'b1, 32'h100, 32'h0);
        ls_drive(1, 1'b1, 1'b0, SZ_H, 1'b0, 32'h206, 32'h0);
        for (int t = 0; t < 4; t++) begin
            exp_ch = t % 2;
            tick();
            chk("rr_addr_b", b1.addr_b, (exp_ch == 0) ? 32'h100 : 32'h204);
            tick();
            chk("rr_done", b1.ls_done, (exp_ch == 0) ? 2'b01 : 2'b10);
            chk("rr_data", b1.ls_data, (exp_ch == 0) ? 32'hDEADBEEF : 32'hFFFF9234);
            if (t == 3) b1.ls_valid = '0;
            tick();
            chk("rr_done_clr", b1.ls_done, 0);
        end

        // Concurrent fetch and load issued on the same edge
        b1.if_valid = 1'b1;
        b1.if_addr  = 32'h204;
        ls_drive(0, 1'b1, 1'b0, SZ_W, 1'b1, 32'h100, 32'h0);
        tick();
        tick();
        chk("cc_if_done", b1.if_done, 1);
        chk("cc_ls_done", b1.ls_done, 2'b01);
        chk("cc_if_data", b1.if_data, 32'h92345678);
        chk("cc_ls_data", b1.ls_data, 32'hDEADBEEF);
        b1.if_valid    = 1'b0;
        b1.ls_valid[0] = 1'b0;
        tick();

`ifdef MEM_CTRL_MISALIGN_CHK_EN
        // Misaligned word load is rejected without touching the RAM
        ls_drive(0, 1'b1, 1'b0, SZ_W, 1'b0, 32'h202, 32'h0);
        tick();
        chk("mis_done", b1.ls_done, 2'b01);
        chk("mis_err",  b1.ls_err, 1);
        chk("mis_be_b", b1.be_b, 0);
        chk("mis_addr_b", b1.addr_b, 0);
        chk("mis_data_unchanged", b1.ls_data, 32'hDEADBEEF);
        b1.ls_valid[0] = 1'b0;
        tick();
        chk("mis_done_clr", b1.ls_done, 0);
        chk("mis_err_clr",  b1.ls_err, 0);
`else
        // Misaligned word store: lanes past the word boundary are dropped
        ls_drive(0, 1'b1, 1'b1, SZ_W, 1'b0, 32'h302, 32'hAABBCCDD);
        tick();
        chk("trunc_addr_b", b1.addr_b, 32'h300);
        chk("trunc_be_b",   b1.be_b, 4'b1100);
        chk("trunc_src_b",  b1.src_b, 32'hCCDD0000);
        tick();
        chk("trunc_done", b1.ls_done, 2'b01);
        b1.ls_valid[0] = 1'b0;
        tick();
`endif

        // Reset while both ports are waiting: no done pulse, outputs cleared
        b1.if_valid = 1'b1;
        b1.if_addr  = 32'h100;
        ls_drive(0, 1'b1, 1'b1, SZ_B, 1'b0, 32'h301, 32'h77);
        tick();
        chk("rw_be_b_pre",  b1.be_b, 4'b0010);
        chk("rw_src_b_pre", b1.src_b, 32'h00007700);
        rst = 1'b1;
        tick();
        chk("rw_if_done", b1.if_done, 0);
        chk("rw_ls_done", b1.ls_done, 0);
        chk("rw_addr_a",  b1.addr_a, 0);
        chk("rw_addr_b",  b1.addr_b, 0);
        chk("rw_be_b",    b1.be_b, 0);
        chk("rw_src_b",   b1.src_b, 0);
        chk("rw_if_data", b1.if_data, 0);
        chk("rw_ls_data", b1.ls_data, 0);
        b1.if_valid = 1'b0;
        b1.ls_valid = '0;
        rst = 1'b0;
        tick();
        chk("rw_post_ls_done", b1.ls_done, 0);
        chk("rw_post_if_done", b1.if_done, 0);
        chk("rw_post_b_state", b1.b_state, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_arb.md
Name: mem_ctrl_arb

Overview:
- Parametrised successor memory controller sitting between the core front-end/LSU and the dual-port block RAM.
- Port A: read-only instruction fetch.
- Port B: shared by NUM_LS load/store channels under round-robin arbitration, with byte/half/word access sizes, byte-enables and sign/zero extension.
- RAM read latency is configurable; each port runs an independent FSM.

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: RAM word width; multiple of 8, at most 64.
- NUM_LS, 2: number of load/store channels on port B; 1 to 4.
- RAM_LAT, 1: cycles from address driven to RAM data valid; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_WIDTH  fetch byte address, word-aligned.
- if_done  out  1  one-cycle completion pulse.
- if_data  out  DATA_WIDTH  fetched word; held until next completion.
- ls_valid  in  NUM_LS  per-channel request; held until that channel's ls_done.
- ls_we  in  NUM_LS  1 = store.
- ls_size  in  2*NUM_LS  per-channel: 0 = byte, 1 = half, 2 = word, 3 = dword (only if DATA_WIDTH = 64).
- ls_unsigned  in  NUM_LS  load zero-extend when 1, sign-extend when 0.
- ls_addr  in  NUM_LS*ADDR_WIDTH  per-channel byte address.
- ls_src  in  NUM_LS*DATA_WIDTH  per-channel store data, right-aligned.
- ls_done  out  NUM_LS  one-cycle pulse for the served channel only.
- ls_data  out  DATA_WIDTH  load result, extended; shared, valid while ls_done is high, held afterwards.
- addr_a  out  ADDR_WIDTH  RAM port A address.
- data_a  in  DATA_WIDTH  RAM port A read data.
- addr_b  out  ADDR_WIDTH  RAM port B address, low OFF bits forced to 0.
- be_b  out  DATA_WIDTH/8  byte write enables; all 0 means read.
- src_b  out  DATA_WIDTH  lane-aligned write data.
- data_b  in  DATA_WIDTH  RAM port B read data.

Behaviour:
- Definitions:
  - OFF = log2(DATA_WIDTH/8).
  - off = addr[OFF-1:0].
- Reset: if_done, ls_done, addr_a, addr_b, be_b, src_b, if_data, ls_data, wait counters = 0; both FSMs IDLE; round-robin pointer = channel 0.
- Port A FSM, IDLE -> WAIT -> DONE -> IDLE:
  - IDLE with if_valid: register addr_a <= if_addr, load cnt <= RAM_LAT-1, go to WAIT.
  - WAIT: decrement cnt each cycle. At the edge where cnt == 0, capture if_data <= data_a, if_done <= 1, addr_a <= 0, go to DONE.
  - DONE: if_done <= 0, return to IDLE. Requests are not accepted in DONE, so a still-high if_valid is not re-issued.
  - Latency: valid sampled at edge 0 -> if_done high after edge RAM_LAT+1. One access per RAM_LAT+2 cycles.
- Port B FSM, same IDLE/WAIT/DONE structure:
  - Arbitration (IDLE): grant g = first valid channel starting at the pointer, wrapping modulo NUM_LS. Pointer <= g+1 mod NUM_LS on grant. A single requester is granted every time.
  - Issue: addr_b <= word-aligned address. Store: be_b <= ((1<<(1<<size))-1) << off, src_b <= ls_src[g] << (8*off). Load: be_b <= 0.
  - Completion (cnt == 0):
    - Load: ls_data <= extend(data_b >> 8*off, size, unsigned).
    - Store: ls_data unchanged.
    - Both: ls_done[g] <= 1; clear addr_b, be_b, src_b.
  - DONE: ls_done <= 0, then IDLE.
- Simultaneous events:
  - Ports A and B operate fully independently.
  - A request arriving while busy waits; there is no queueing beyond the held valid.
  - A channel dropping valid before done is protocol violation; behaviour undefined.
- Misaligned access (off not a multiple of the access size): without the optional feature, bytes that would cross the word boundary are dropped (be_b truncated to DATA_WIDTH/8 bits).
- Reset mid-operation: the in-flight access is abandoned; no done pulse is produced; outputs go to reset values at that edge.

Optional Feature:
- MEM_CTRL_MISALIGN_CHK_EN: adds output ls_err (1 bit).
- Defined:
  - A misaligned grant issues no RAM access: be_b = 0, addr_b unchanged at 0.
  - The FSM goes directly to DONE, asserting ls_done[g] and ls_err for one cycle; ls_data is unchanged.
  - Latency for the error path: 1 cycle.
- Undefined: the port is absent; truncation behaviour as above.

Decomposition:
- Package mem_ctrl_pkg holds:
  - Size encodings: SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3.
  - FSM state enum: IDLE, WAIT, DONE.
  - Functions for byte-enable generation and load extension.
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant and grant index out, with pointer update on an accept strobe. Reusable by the LSU.

Test Plan:
- Fetch, RAM_LAT=1: if_addr=0x100, RAM word 0xDEADBEEF -> addr_a=0x100 after edge 1; if_done pulses one cycle after edge 2 with if_data=0xDEADBEEF; no re-issue while if_valid is still high in DONE.
- RAM_LAT=3 fetch -> if_done exactly 4 edges after request, single pulse.
- Byte store channel 0: addr=0x203, src=0x5A -> addr_b=0x200, be_b=4'b1000, src_b=0x5A000000. Then a signed byte load of 0x203 returns 0x0000005A. After storing 0x80 there, the signed load returns 0xFFFFFF80 and the unsigned load returns 0x00000080.
- NUM_LS=2, both channels holding valid continuously -> grants alternate 0,1,0,1; each ls_done pulses only on its own bit.
- Concurrent fetch and load issued on the same edge -> both complete on the same edge, with independent correct data.
- rst asserted during WAIT -> no done pulse; all outputs 0 next cycle. With MEM_CTRL_MISALIGN_CHK_EN, a word load at 0x202 -> ls_err and ls_done for 1 cycle, be_b stays 0.
